// File: rtl/muxn_sched.sv
// rtl/muxn_sched.sv - round-robin scheduler sharing the 4-lane MUXN datapath between four requesters
// Optional feature macro: MUXN_SCHED_BURST_EN (holder keeps priority for up to BURST_MAX transfers)
module muxn_sched #(
  parameter int BURST_MAX = 4
) (
  input  logic        inClock,
  input  logic        inReset,
  input  logic [3:0]  inReq,
  input  logic [15:0] inReqData,
  input  logic        inFlush,
  output logic [3:0]  outGrant,
  output logic [1:0]  outSel,
  output logic [3:0]  outMuxData,
  output logic        outMuxEnable,
  output logic        outValid,
  output logic [1:0]  outLane,
  output logic        outBusy,
  output logic        outFlushDone
);

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] ptr;
  logic       drain_cnt;
  logic       flush_done_next;
  logic       d1_en;
  logic [1:0] d1_sel;
  logic [3:0] rr_grant;
  logic [3:0] grant;
  logic       grant_ok;
  logic       xfer;
  logic [1:0] xfer_lane;

  generate
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
      $error("muxn_sched: BURST_MAX must be in 1..15");
    end
  endgenerate

  assign grant_ok = (state != DRAIN) && !inFlush;

  // Scan from ptr+1 upward; iterating downward lets the nearest lane overwrite.
  always_comb begin
    logic [1:0] idx;
    rr_grant = 4'b0000;
    idx      = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (inReq[idx]) rr_grant = 4'b0001 << idx;
    end
  end

`ifdef MUXN_SCHED_BURST_EN
  localparam logic [3:0] BurstLimit = 4'(BURST_MAX);
  logic [3:0] burst_cnt;
  logic       burst_hold;

  // A nonzero count means ptr transferred on the previous edge.
  assign burst_hold = (burst_cnt != 4'd0) && (burst_cnt < BurstLimit) && inReq[ptr];
  assign grant      = !grant_ok  ? 4'b0000 :
                      burst_hold ? (4'b0001 << ptr) : rr_grant;
`else
  assign grant = grant_ok ? rr_grant : 4'b0000;
`endif

  assign outGrant = grant;
  assign xfer     = |grant;

  always_comb begin
    xfer_lane = 2'd0;
    unique case (grant)
      4'b0010: xfer_lane = 2'd1;
      4'b0100: xfer_lane = 2'd2;
      4'b1000: xfer_lane = 2'd3;
      default: xfer_lane = 2'd0;
    endcase
  end

  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (inFlush)   state_next = DRAIN;
        else if (xfer) state_next = SERVE;
      end
      SERVE: begin
        if (inFlush)    state_next = DRAIN;
        else if (!xfer) state_next = IDLE;
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_next      = IDLE;
          flush_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      drain_cnt    <= 1'b0;
      outFlushDone <= 1'b0;
      outSel       <= 2'd0;
      outMuxData   <= 4'd0;
      outMuxEnable <= 1'b0;
      d1_en        <= 1'b0;
      d1_sel       <= 2'd0;
      outValid     <= 1'b0;
      outLane      <= 2'd0;
    end else begin
      state        <= state_next;
      outFlushDone <= flush_done_next;
      drain_cnt    <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      outMuxEnable <= xfer;
      if (xfer) begin
        outSel     <= xfer_lane;
        outMuxData <= inReqData[xfer_lane*4 +: 4];
        ptr        <= xfer_lane;
      end
      // Mirrors the datapath's capture and output registers.
      d1_en    <= outMuxEnable;
      d1_sel   <= outSel;
      outValid <= d1_en;
      outLane  <= d1_sel;
    end
  end

`ifdef MUXN_SCHED_BURST_EN
  always_ff @(posedge inClock) begin
    if (inReset) begin
      burst_cnt <= 4'd0;
    end else if (state == DRAIN || !xfer) begin
      burst_cnt <= 4'd0;
    end else if (xfer_lane == ptr && burst_cnt != 4'd0) begin
      if (burst_cnt < BurstLimit) burst_cnt <= burst_cnt + 4'd1;
    end else begin
      burst_cnt <= 4'd1;
    end
  end
`endif

  assign outBusy = (state != IDLE) | outMuxEnable | d1_en | outValid;

endmodule

// File: tb/tb_muxn_sched.sv
// tb/tb_muxn_sched.sv - directed self-checking bench for muxn_sched (either MUXN_SCHED_BURST_EN build)
module tb_muxn_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data;
  logic        flush;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [3:0]  mux_data;
  logic        mux_en;
  logic        valid;
  logic [1:0]  lane;
  logic        busy;
  logic        flush_done;

  int errors = 0;
  int checks = 0;
  int exp_lane [8];

  muxn_sched #(.BURST_MAX(2)) dut (
    .inClock      (clk),
    .inReset      (rst),
    .inReq        (req),
    .inReqData    (data),
    .inFlush      (flush),
    .outGrant     (grant),
    .outSel       (sel),
    .outMuxData   (mux_data),
    .outMuxEnable (mux_en),
    .outValid     (valid),
    .outLane      (lane),
    .outBusy      (busy),
    .outFlushDone (flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 4'b0000;
    data  = 16'h0000;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef MUXN_SCHED_BURST_EN
    exp_lane = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp_lane = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_data", 32'(mux_data), 32'h0);
    check("rst_en", 32'(mux_en), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(flush_done), 32'h0);

    // Single transfer on lane 0
    req = 4'b0001; data = 16'h000A;
    #1 check("single_grant", 32'(grant), 32'h1);
    tick();
    check("single_data", 32'(mux_data), 32'hA);
    check("single_sel", 32'(sel), 32'h0);
    check("single_en", 32'(mux_en), 32'h1);
    req = 4'b0000;
    #1 check("single_nogrant", 32'(grant), 32'h0);
    tick();
    check("single_en_off", 32'(mux_en), 32'h0);
    check("single_valid_early", 32'(valid), 32'h0);
    tick();
    check("single_valid", 32'(valid), 32'h1);
    check("single_lane", 32'(lane), 32'h0);
    tick();
    check("single_valid_end", 32'(valid), 32'h0);
    check("single_busy_end", 32'(busy), 32'h0);

    // All four lanes requesting continuously
    do_reset();
    req = 4'b1111; data = 16'h4321;
    for (int c = 0; c < 8; c++) begin
      #1 check("rr_grant", 32'(grant), 32'(1) << exp_lane[c]);
      tick();
      check("rr_data", 32'(mux_data), 32'(exp_lane[c] + 1));
      if (c >= 2) begin
        check("rr_valid", 32'(valid), 32'h1);
        check("rr_lane", 32'(lane), 32'(exp_lane[c-2]));
      end
    end

    // Flush raised in cycle 5 with requests still present
    do_reset();
    req = 4'b1111; data = 16'h4321;
    for (int c = 0; c < 4; c++) tick();
    flush = 1'b1;
    #1 check("flush_grant", 32'(grant), 32'h0);
    tick();
    check("flush_en", 32'(mux_en), 32'h0);
    check("flush_valid_f", 32'(valid), 32'h1);
    check("flush_lane_f", 32'(lane), 32'(exp_lane[2]));
    check("flush_busy", 32'(busy), 32'h1);
    flush = 1'b0;
    #1 check("drain_grant", 32'(grant), 32'h0);
    tick();
    check("drain_valid", 32'(valid), 32'h1);
    check("drain_lane", 32'(lane), 32'(exp_lane[3]));
    check("drain_done_early", 32'(flush_done), 32'h0);
    req = 4'b0000;
    tick();
    check("drain_done", 32'(flush_done), 32'h1);
    check("drain_busy", 32'(busy), 32'h0);
    check("drain_valid_off", 32'(valid), 32'h0);
    tick();
    check("drain_done_pulse", 32'(flush_done), 32'h0);
    check("drain_busy_after", 32'(busy), 32'h0);

    // Reset one cycle after a lane 2 transfer
    do_reset();
    req = 4'b0100; data = 16'h0500;
    tick();
    check("mid_en", 32'(mux_en), 32'h1);
    rst = 1'b1; req = 4'b0000;
    tick();
    check("mid_rst_en", 32'(mux_en), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    check("mid_stale1", 32'(valid), 32'h0);
    tick();
    check("mid_stale2", 32'(valid), 32'h0);
    req = 4'b1010;
    #1 check("mid_lowest", 32'(grant), 32'h2);

    // Lane 2 holds, lane 1 joins after lane 2 was granted
    do_reset();
    req = 4'b0100; data = 16'h0760;
    #1 check("wait_g2", 32'(grant), 32'h4);
    tick();
    req = 4'b0110;
`ifdef MUXN_SCHED_BURST_EN
    #1 check("wait_burst_g2", 32'(grant), 32'h4);
    tick();
`endif
    #1 check("wait_g1", 32'(grant), 32'h2);
    tick();
    check("wait_data1", 32'(mux_data), 32'h6);
    req = 4'b0100;
    #1 check("wait_back_g2", 32'(grant), 32'h4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muxn_sched.md
# muxn_sched

Round-robin scheduler that shares the 4-lane registered demultiplexer (MUXN) between four requesters. Each cycle it selects at most one requesting lane, drives the datapath's select, data and enable inputs, and tracks the datapath's two-cycle pipeline so downstream logic knows when `outData` of the datapath is valid and which lane it carries. It also provides a drain/flush sequence that stops new grants and signals when the datapath pipeline is empty.

## Interface
Parameters:
- `BURST_MAX`, default 4: maximum consecutive transfers per grant holder; used only when `MUXN_SCHED_BURST_EN` is defined; legal range 1..15.

Ports:
- `inClock`  in  1  the only clock; all state updates on the rising edge.
- `inReset`  in  1  synchronous, active-high reset.
- `inReq`  in  4  per-lane request; bit i belongs to requester i.
- `inReqData`  in  16  per-lane data word; lane i occupies bits [4i+3:4i].
- `inFlush`  in  1  level request to stop granting and drain the datapath.
- `outGrant`  out  4  one-hot grant; combinational, at most one bit high.
- `outSel`  out  2  registered; drives the datapath's select input.
- `outMuxData`  out  4  registered; drives the datapath's data input.
- `outMuxEnable`  out  1  registered; drives the datapath's enable input (its active-high `inReset` pin).
- `outValid`  out  1  registered; high when the datapath output holds a transferred word.
- `outLane`  out  2  registered; lane index matching `outValid`.
- `outBusy`  out  1  high while any transfer is in flight or the FSM is not IDLE.
- `outFlushDone`  out  1  one-cycle pulse when a drain completes.

## Operation
- FSM states: IDLE, SERVE, DRAIN.
  - IDLE → SERVE on any transfer.
  - SERVE → IDLE when no transfer occurs in a cycle.
  - IDLE/SERVE → DRAIN when `inFlush` is high.
  - DRAIN → IDLE after 2 cycles; `outFlushDone` pulses on that transition.
- Grant: in IDLE/SERVE with `inFlush` low, `outGrant` is the first requesting lane scanning from `ptr+1` mod 4 upward. It is 0 in DRAIN, when `inFlush` is high, and when no request is present.
- Transfer: occurs on any edge where `inReq[i] & outGrant[i]`. On a transfer, `outSel<=i`, `outMuxData<=inReqData[4i+3:4i]`, `outMuxEnable<=1` and `ptr<=i`. With no transfer, `outMuxEnable<=0`; `outSel` and `outMuxData` hold their values.
- Delay line: two-stage shift of {enable, sel} feeding `outValid`/`outLane`.
- `outBusy` = (state != IDLE) | `outMuxEnable` | delay stage 1 | `outValid`.
- Reset (synchronous, overrides everything, including mid-drain and mid-pipeline): state=IDLE, `ptr`=3 (lane 0 has first priority), `outSel`=0, `outMuxData`=0, `outMuxEnable`=0, delay line=0, `outValid`=0, `outLane`=0, `outFlushDone`=0, burst count=0. Because `outGrant` is combinational, it is 0 whenever `inReq`=0.
- Requesters hold `inReq` and data stable until granted. Dropping `inReq` before a grant is legal and discards the request.

## Timing
- Grant to transfer: same cycle (combinational grant, edge-qualified transfer).
- Transfer at edge E0: `outSel`/`outMuxData`/`outMuxEnable` are valid after E0. The datapath captures them at E1 and registers its output at E2. `outValid`/`outLane` are high after E2, aligned with the datapath's `outData`.
- Throughput: one transfer per cycle, back-to-back.
- `inFlush` and a request in the same cycle: the flush wins and no transfer occurs. The drain covers the last in-flight word: entering DRAIN at edge F, `outFlushDone` pulses after F+2, and the final `outValid` of a word transferred at F-1 appears after F+1.
- `inFlush` while in DRAIN is ignored. If it is still high when DRAIN exits, the FSM re-enters DRAIN on the next edge.

## Configuration
- `MUXN_SCHED_BURST_EN` defined: a per-holder burst counter. While the last granted lane keeps `inReq` high and fewer than `BURST_MAX` consecutive transfers have been made, it keeps priority over the round-robin scan. The counter resets on holder change, idle cycle, DRAIN or reset.
- Not defined: pure round-robin. The pointer advances on every transfer, and no burst counter exists in the RTL.

## Test plan
- Reset then `inReq`=4'b0001, lane0 data=4'hA → `outGrant`=0001 and `outMuxData`=A, `outSel`=0 after the edge; `outValid`=1, `outLane`=0 two edges later.
- `inReq`=4'b1111 held for 8 cycles (no burst macro) → grants in order 0,1,2,3,0,1,2,3; `outValid` is continuous from cycle 3.
- Same stimulus with `MUXN_SCHED_BURST_EN`, `BURST_MAX`=2 → grants 0,0,1,1,2,2,3,3.
- Continuous requests, raise `inFlush` at cycle 5 → `outGrant`=0 from cycle 5; `outFlushDone` pulses exactly 2 cycles later; `outBusy`=0 the cycle after, with no request present.
- Assert `inReset` one cycle after a transfer → `outMuxEnable`, `outValid` and `outBusy` are 0 after that edge; no stale `outValid` follows; the next grant goes to the lowest requesting lane.
- Lane2 holds `inReq`, lane1 requests one cycle later after lane2 was granted (ptr=2) → grant order is 2, then 3 if requesting, else 0, else 1; lane1 waits no more than 3 transfers.
